// File: rtl/mem_bist_initiator_if.sv
// Memory request/response bus between the BIST initiator and the memory under test.
// The master issues one-cycle requests; the slave answers with a ready strobe.
interface mem_bist_initiator_if;
  logic        valid;
  logic        wr_rd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        error;
  logic [31:0] rdata;

  modport master (
    output valid, wr_rd, addr, wdata,
    input  ready, error, rdata
  );

  modport slave (
    input  valid, wr_rd, addr, wdata,
    output ready, error, rdata
  );
endinterface

// File: rtl/mem_bist_initiator.sv
// Memory BIST initiator: writes pattern^addr over an address range, reads it back,
// and reports failures, the first failing address and ready timeouts.
module mem_bist_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [31:0]                 start_addr,
  input  logic [31:0]                 last_addr,
  input  logic [31:0]                 pattern,
  mem_bist_initiator_if.master        mem,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [15:0]                 err_count,
  output logic [31:0]                 first_fail_addr
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_t;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t        state_q;
  logic          valid_q, wr_rd_q, busy_q, done_q, pass_q, timeout_q;
  logic [31:0]   addr_q, wdata_q, first_fail_q;
  logic [31:0]   start_addr_q, last_addr_q, pattern_q;
  logic [15:0]   err_count_q;
  logic [CW-1:0] wait_cnt_q;

  logic          resp_fail;
  logic          at_last;
  logic [15:0]   err_count_d;
  logic [31:0]   next_addr;

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    resp_fail   = mem.error ||
                  ((state_q == RD_WAIT) && (mem.rdata != (pattern_q ^ addr_q)));
    err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
    at_last     = (addr_q == last_addr_q);
    next_addr   = addr_q + 32'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      wr_rd_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      start_addr_q <= '0;
      last_addr_q  <= '0;
      pattern_q    <= '0;
      wait_cnt_q   <= '0;
    end else begin
      // Strobes default low so each request and the done pulse last exactly one cycle.
      valid_q <= 1'b0;
      done_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            start_addr_q <= start_addr;
            last_addr_q  <= last_addr;
            pattern_q    <= pattern;
            addr_q       <= start_addr;
            err_count_q  <= '0;
            timeout_q    <= 1'b0;
            first_fail_q <= '0;
            if (start_addr <= last_addr) begin
              state_q <= WR_REQ;
              busy_q  <= 1'b1;
              pass_q  <= 1'b0;
              valid_q <= 1'b1;
              wr_rd_q <= 1'b1;
              wdata_q <= pattern ^ start_addr;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
          end
        end

        // The wait counter includes the request cycle, so an abort lands TIMEOUT cycles after valid.
        WR_REQ: begin
          state_q    <= WR_WAIT;
          wait_cnt_q <= CW'(1);
        end

        RD_REQ: begin
          state_q    <= RD_WAIT;
          wait_cnt_q <= CW'(1);
        end

        WR_WAIT, RD_WAIT: begin
          if (mem.ready) begin
            if (resp_fail) begin
              err_count_q <= err_count_d;
              if (err_count_q == 16'd0) first_fail_q <= addr_q;
            end
            if (!at_last) begin
              addr_q  <= next_addr;
              wdata_q <= pattern_q ^ next_addr;
              valid_q <= 1'b1;
              state_q <= (state_q == WR_WAIT) ? WR_REQ : RD_REQ;
            end else if (state_q == WR_WAIT) begin
              addr_q  <= start_addr_q;
              valid_q <= 1'b1;
              wr_rd_q <= 1'b0;
              state_q <= RD_REQ;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pass_q  <= (err_count_q == 16'd0) && !resp_fail;
            end
          end else if (wait_cnt_q >= CW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end

        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.valid       = valid_q;
  assign mem.wr_rd       = wr_rd_q;
  assign mem.addr        = addr_q;
  assign mem.wdata       = wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign err_count       = err_count_q;
  assign first_fail_addr = first_fail_q;

endmodule

// File: doc/mem_bist_initiator.md
MEM_BIST_INITIATOR -- requirements
Module: mem_bist_initiator

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum cycles to wait for ready after each request.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  one-cycle pulse that launches a test run.
REQ-005 Port: start_addr  input  32  first word address of the test range.
REQ-006 Port: last_addr  input  32  last word address of the test range, inclusive.
REQ-007 Port: pattern  input  32  pattern seed; expected data at address a is pattern XOR a.
REQ-008 Port: valid  output  1  memory request strobe.
REQ-009 Port: wr_rd  output  1  request type: 1 = write, 0 = read.
REQ-010 Port: addr  output  32  request word address.
REQ-011 Port: wdata  output  32  write data.
REQ-012 Port: ready  input  1  memory response strobe.
REQ-013 Port: error  input  1  memory error flag, qualified by ready.
REQ-014 Port: rdata  input  32  read data, qualified by ready.
REQ-015 Port: busy  output  1  run in progress.
REQ-016 Port: done  output  1  one-cycle pulse at the end of a run.
REQ-017 Port: pass  output  1  result of the last run; valid from done until the next start.
REQ-018 Port: timeout  output  1  the last run was aborted on a ready timeout.
REQ-019 Port: err_count  output  16  failures in the last run (error responses plus read mismatches), saturating at 0xFFFF.
REQ-020 Port: first_fail_addr  output  32  address of the first failure in the last run.

Function
REQ-021 FSM states SHALL be IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT and DONE.
REQ-022 start SHALL be accepted in IDLE only and ignored in every other state.
- On acceptance: load the address counter with start_addr, clear err_count, timeout and first_fail_addr, set busy.
- If start_addr <= last_addr, go to WR_REQ.
- If start_addr > last_addr, go to DONE with no requests issued and pass=1.
REQ-023 valid SHALL be high for exactly one cycle, and only in WR_REQ or RD_REQ.
- addr, wr_rd and wdata are driven in that same cycle.
- In WR_REQ, wdata = pattern ^ addr.
- A request is never held high for a second cycle, so the memory never sees a duplicate request.
REQ-024 In WR_WAIT and RD_WAIT the block SHALL sample ready every cycle.
- ready seen in any other state is ignored.
REQ-025 On ready with error=1, err_count SHALL increment.
REQ-026 In RD_WAIT, on ready with error=0 and rdata != (pattern ^ addr), err_count SHALL increment.
REQ-027 On the first failure of a run, first_fail_addr SHALL capture addr.
REQ-028 After a response, if addr == last_addr the phase ends; otherwise addr increments and the FSM returns to the request state.
- The equality check happens before the increment, so last_addr = 0xFFFFFFFF never wraps.
REQ-029 When the write phase ends, the FSM SHALL reload addr with start_addr and go to RD_REQ; when the read phase ends, it goes to DONE.
REQ-030 With a memory that responds one cycle after the request, each transaction SHALL take 2 cycles.
REQ-031 Wait timeout SHALL work as follows.
- A wait counter clears on entry to WR_WAIT or RD_WAIT and increments each cycle without ready.
- When it reaches TIMEOUT, the run aborts: timeout=1, pass=0, go to DONE.
REQ-032 DONE SHALL last one cycle.
- done=1 and busy drops; pass = (err_count==0 && !timeout); then return to IDLE.
- pass, timeout, err_count and first_fail_addr hold until the next accepted start.

Reset
REQ-033 While rst_n is low, asynchronously:
- state=IDLE;
- valid, wr_rd, busy, done, pass and timeout = 0;
- addr, wdata, err_count and first_fail_addr = 0.
REQ-034 Reset asserted mid-run SHALL abort the run immediately, with valid low in the same cycle and no done pulse.
REQ-035 After rst_n rises, the block SHALL accept a start on the first clock edge.

Verification
REQ-036 start_addr=0, last_addr=3, pattern=0xA5A5A5A5, ideal memory -> writes 0xA5A5A5A5, 0xA5A5A5A4, 0xA5A5A5A7, 0xA5A5A5A6 to addresses 0-3, then 4 reads, then done, pass=1, err_count=0; 16 cycles from the first valid to done.
REQ-037 Same run with the memory model flipping bit 0 of rdata at address 2 -> err_count=1, first_fail_addr=2, pass=0.
REQ-038 start_addr=1022, last_addr=1025 against a 1024-word memory -> error responses at 1024 and 1025 in both phases, err_count=4, first_fail_addr=1024, pass=0.
REQ-039 ready tied low -> one valid pulse, then done exactly TIMEOUT (16) cycles later, timeout=1, pass=0, busy=0.
REQ-040 start_addr=5, last_addr=4 -> no valid ever asserted, done the next cycle, pass=1, err_count=0.
REQ-041 rst_n pulsed low during the read phase -> valid and busy drop immediately, counters read 0, no done pulse; a new start then runs to completion.
